// File: rtl/pic_8259a_pkg.sv
// Shared types and defaults for the 8259A PIC interrupt-acknowledge path.
package pic_8259a_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_INTA1   = 3'd1,
      ST_GAP     = 3'd2,
      ST_INTA2   = 3'd3,
      ST_VALID   = 3'd4,
      ST_RECOVER = 3'd5
   } inta_state_t;

   localparam int PIC_INTA_LOW_CYCLES = 2;
   localparam int PIC_INTA_GAP_CYCLES = 2;
   localparam int PIC_IRQ_SYNC_STAGES = 2;

   localparam logic [7:0] PIC_SPURIOUS_VECTOR = 8'h00;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/irq_synchronizer.sv
// Multi-stage flop chain bringing the asynchronous PIC INT line into the clock domain.
module irq_synchronizer #(
   parameter int STAGES = 2
) (
   input  logic clock,
   input  logic reset_n,
   input  logic async_in,
   output logic sync_out
);

   logic [STAGES-1:0] sync_r;

   // Shift chain, cleared to 0 on reset.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync_r <= {STAGES{1'b0}};
      end else begin
         sync_r <= {sync_r[STAGES-2:0], async_in};
      end
   end

   assign sync_out = sync_r[STAGES-1];

endmodule

// File: rtl/inta_cycle_sequencer.sv
// Generates the two-pulse INTA sequence toward the 8259A, captures the vector
// on the second pulse and offers it to the CPU over valid/ready.
module inta_cycle_sequencer
   import pic_8259a_pkg::*;
#(
   parameter int IRQ_SYNC_STAGES = PIC_IRQ_SYNC_STAGES,
   parameter int INTA_LOW_CYCLES = PIC_INTA_LOW_CYCLES,
   parameter int INTA_GAP_CYCLES = PIC_INTA_GAP_CYCLES
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       interrupt_to_cpu,
   input  logic       cpu_interrupt_enable,
   output logic       interrupt_acknowledge_n,
   input  logic [7:0] data_bus_in,
   input  logic       data_bus_io,
   output logic [7:0] vector,
   output logic       vector_valid,
   input  logic       vector_ready,
   output logic       spurious,
   output logic       busy
);

   localparam int CNT_W = $clog2(max3(INTA_LOW_CYCLES, INTA_GAP_CYCLES, IRQ_SYNC_STAGES + 1)) + 1;
   localparam logic [CNT_W-1:0] LOW_LOAD = CNT_W'(INTA_LOW_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(INTA_GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] REC_LOAD = CNT_W'(IRQ_SYNC_STAGES);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   inta_state_t      state_r, state_d;
   logic [CNT_W-1:0] cnt_r, cnt_d;
   logic             irq_sync_s;
   logic             inta_n_r, inta_n_d;
   logic             valid_r, valid_d;
   logic             busy_r, busy_d;
   logic [7:0]       vector_r, vector_d;
   logic             spurious_r, spurious_d;

   irq_synchronizer #(
      .STAGES (IRQ_SYNC_STAGES)
   ) u_irq_sync (
      .clock    (clock),
      .reset_n  (reset_n),
      .async_in (interrupt_to_cpu),
      .sync_out (irq_sync_s)
   );

   // State and shared down-counter registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= ST_IDLE;
         cnt_r   <= CNT_ZERO;
      end else begin
         state_r <= state_d;
         cnt_r   <= cnt_d;
      end
   end

   // Next-state and counter logic; a started sequence always runs to completion.
   always_comb begin
      state_d = state_r;
      cnt_d   = cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (irq_sync_s && cpu_interrupt_enable) begin
               state_d = ST_INTA1;
               cnt_d   = LOW_LOAD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_INTA1: begin
            if (cnt_r == CNT_ZERO) begin
               state_d = ST_GAP;
               cnt_d   = GAP_LOAD;
            end else begin
               cnt_d = cnt_r - CNT_ONE;
            end
         end
         ST_GAP: begin
            if (cnt_r == CNT_ZERO) begin
               state_d = ST_INTA2;
               cnt_d   = LOW_LOAD;
            end else begin
               cnt_d = cnt_r - CNT_ONE;
            end
         end
         ST_INTA2: begin
            if (cnt_r == CNT_ZERO) begin
               state_d = ST_VALID;
            end else begin
               cnt_d = cnt_r - CNT_ONE;
            end
         end
         ST_VALID: begin
            if (vector_ready) begin
               state_d = ST_RECOVER;
               cnt_d   = REC_LOAD;
            end else begin
               state_d = ST_VALID;
            end
         end
         ST_RECOVER: begin
            if (cnt_r == CNT_ZERO) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_r - CNT_ONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
         end
      endcase
   end

   // Output values decoded from the upcoming state so every output is a flop.
   always_comb begin
      inta_n_d   = !((state_d == ST_INTA1) || (state_d == ST_INTA2));
      valid_d    = (state_d == ST_VALID);
      busy_d     = (state_d != ST_IDLE);
      vector_d   = vector_r;
      spurious_d = spurious_r;
      if ((state_r == ST_INTA2) && (state_d == ST_VALID)) begin
         vector_d   = data_bus_io ? PIC_SPURIOUS_VECTOR : data_bus_in;
         spurious_d = data_bus_io;
      end else begin
         vector_d   = vector_r;
         spurious_d = spurious_r;
      end
   end

   // Output registers; reset drives INTA high without waiting for a clock.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         inta_n_r   <= 1'b1;
         valid_r    <= 1'b0;
         busy_r     <= 1'b0;
         vector_r   <= 8'h00;
         spurious_r <= 1'b0;
      end else begin
         inta_n_r   <= inta_n_d;
         valid_r    <= valid_d;
         busy_r     <= busy_d;
         vector_r   <= vector_d;
         spurious_r <= spurious_d;
      end
   end

   assign interrupt_acknowledge_n = inta_n_r;
   assign vector_valid            = valid_r;
   assign busy                    = busy_r;
   assign vector                  = vector_r;
   assign spurious                = spurious_r;

endmodule
